// File: rtl/rtc_write_pkg.sv
// Shared definitions for the RTC write sequencer: FSM encoding, default
// strobe timings and the AoD levels used on the multiplexed bus.
package rtc_write_pkg;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_A_SETUP = 4'd1;
    localparam logic [3:0] ST_A_PULSE = 4'd2;
    localparam logic [3:0] ST_A_HOLD  = 4'd3;
    localparam logic [3:0] ST_GAP     = 4'd4;
    localparam logic [3:0] ST_D_SETUP = 4'd5;
    localparam logic [3:0] ST_D_PULSE = 4'd6;
    localparam logic [3:0] ST_D_HOLD  = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;

    localparam int T_SETUP_DEF = 2;
    localparam int T_PULSE_DEF = 5;
    localparam int T_HOLD_DEF  = 2;
    localparam int T_GAP_DEF   = 4;

    localparam logic AOD_ADDR = 1'b0;
    localparam logic AOD_DATA = 1'b1;

    // The timer counts down to zero, so a phase of N cycles reloads N-1.
    function automatic logic [3:0] phase_load(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 4-bit down-counter; zero marks the last cycle of the current phase.
module rtc_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] count_r;

    // Reload on phase entry, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != 4'd0) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == 4'd0);

endmodule

// File: rtl/rtc_write.sv
// RTC bus write sequencer: address phase, CS-high gap, data phase, done pulse.
// Optional one-entry request queue enabled by defining RTC_WRITE_QUEUE_EN.
module rtc_write
    import rtc_write_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int T_GAP   = T_GAP_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       pending,
    output logic       ChipSelect,
    output logic       Read,
    output logic       Write,
    output logic       AoD,
    output logic [7:0] bus_out,
    output logic       bus_oe
);

    logic [3:0] state_r, state_next_s, load_val_s;
    logic       load_s, zero_s, take_q_s;
    logic [7:0] addr_r, data_r, addr_next_s, data_next_s, q_addr_s, q_data_s;
    logic       cs_s, wr_s, aod_s, oe_s, busy_s, done_s;
    logic [7:0] bus_s;

    rtc_phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_val (load_val_s),
        .zero     (zero_s)
    );

`ifdef RTC_WRITE_QUEUE_EN
    logic       pend_r;
    logic [7:0] q_addr_r, q_data_r;

    assign take_q_s = (state_r == ST_DONE) && pend_r;

    // One-entry holding register; requests in IDLE or DONE are not queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_r   <= 1'b0;
            q_addr_r <= 8'd0;
            q_data_r <= 8'd0;
        end else if (take_q_s) begin
            pend_r <= 1'b0;
        end else if (start && !pend_r && (state_r != ST_IDLE) && (state_r != ST_DONE)) begin
            pend_r   <= 1'b1;
            q_addr_r <= addr;
            q_data_r <= data;
        end else begin
            pend_r <= pend_r;
        end
    end

    assign q_addr_s = q_addr_r;
    assign q_data_s = q_data_r;
    assign pending  = pend_r;
`else
    assign take_q_s = 1'b0;
    assign q_addr_s = 8'd0;
    assign q_data_s = 8'd0;
    assign pending  = 1'b0;
`endif

    // Next state, phase reload value and next latched address/data.
    always_comb begin
        state_next_s = state_r;
        load_val_s   = 4'd0;
        addr_next_s  = addr_r;
        data_next_s  = data_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_A_SETUP;
                    load_val_s   = phase_load(T_SETUP);
                    addr_next_s  = addr;
                    data_next_s  = data;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_A_SETUP: if (zero_s) begin state_next_s = ST_A_PULSE; load_val_s = phase_load(T_PULSE); end
                        else begin state_next_s = ST_A_SETUP; end
            ST_A_PULSE: if (zero_s) begin state_next_s = ST_A_HOLD;  load_val_s = phase_load(T_HOLD);  end
                        else begin state_next_s = ST_A_PULSE; end
            ST_A_HOLD:  if (zero_s) begin state_next_s = ST_GAP;     load_val_s = phase_load(T_GAP);   end
                        else begin state_next_s = ST_A_HOLD; end
            ST_GAP:     if (zero_s) begin state_next_s = ST_D_SETUP; load_val_s = phase_load(T_SETUP); end
                        else begin state_next_s = ST_GAP; end
            ST_D_SETUP: if (zero_s) begin state_next_s = ST_D_PULSE; load_val_s = phase_load(T_PULSE); end
                        else begin state_next_s = ST_D_SETUP; end
            ST_D_PULSE: if (zero_s) begin state_next_s = ST_D_HOLD;  load_val_s = phase_load(T_HOLD);  end
                        else begin state_next_s = ST_D_PULSE; end
            ST_D_HOLD:  if (zero_s) begin state_next_s = ST_DONE;    load_val_s = 4'd0;                end
                        else begin state_next_s = ST_D_HOLD; end
            ST_DONE: begin
                if (take_q_s) begin
                    state_next_s = ST_A_SETUP;
                    load_val_s   = phase_load(T_SETUP);
                    addr_next_s  = q_addr_s;
                    data_next_s  = q_data_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    assign load_s = (state_next_s != state_r);

    // Output levels decoded from the next state so the strobes leave registers.
    always_comb begin
        cs_s   = 1'b1;
        wr_s   = 1'b1;
        aod_s  = AOD_DATA;
        oe_s   = 1'b0;
        bus_s  = 8'd0;
        busy_s = 1'b1;
        done_s = 1'b0;
        case (state_next_s)
            ST_IDLE: busy_s = 1'b0;
            ST_A_SETUP, ST_A_PULSE, ST_A_HOLD: begin
                cs_s  = 1'b0;
                aod_s = AOD_ADDR;
                oe_s  = 1'b1;
                bus_s = addr_next_s;
                wr_s  = (state_next_s == ST_A_PULSE) ? 1'b0 : 1'b1;
            end
            ST_GAP: aod_s = AOD_ADDR; // AoD flips at D_SETUP entry, with CS still high
            ST_D_SETUP, ST_D_PULSE, ST_D_HOLD: begin
                cs_s  = 1'b0;
                aod_s = AOD_DATA;
                oe_s  = 1'b1;
                bus_s = data_next_s;
                wr_s  = (state_next_s == ST_D_PULSE) ? 1'b0 : 1'b1;
            end
            ST_DONE: done_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // State, latched transfer values and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            addr_r     <= 8'd0;
            data_r     <= 8'd0;
            ChipSelect <= 1'b1;
            Read       <= 1'b1;
            Write      <= 1'b1;
            AoD        <= AOD_DATA;
            bus_oe     <= 1'b0;
            bus_out    <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            addr_r     <= addr_next_s;
            data_r     <= data_next_s;
            ChipSelect <= cs_s;
            Read       <= 1'b1;
            Write      <= wr_s;
            AoD        <= aod_s;
            bus_oe     <= oe_s;
            bus_out    <= bus_s;
            busy       <= busy_s;
            done       <= done_s;
        end
    end

endmodule

// File: tb/tb_rtc_write.sv
// Self-checking bench for rtc_write: directed vector table, reset and short-
// timing corner cases, then random traffic against a cycle-offset model.
module tb_rtc_write;

    localparam int TS = 2, TP = 5, TH = 2, TG = 4;
    localparam int LEN  = 2 * (TS + TP + TH) + TG;
    localparam int LEN1 = 2 * (1 + 1 + 1) + 1;
`ifdef RTC_WRITE_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       cs;
        logic       rd;
        logic       wr;
        logic       aod;
        logic       oe;
        logic [7:0] bus;
    } obs_t;

    typedef struct {
        logic [7:0] a, d, a2, d2;
        int         s2, s3;
        int         n, d1, d2t;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, start, start1;
    logic [7:0] addr, data;
    logic       busy, done, pending, cs, rd, wr, aod, oe;
    logic [7:0] bus_out;
    logic       busy1, done1, pending1, cs1, rd1, wr1, aod1, oe1;
    logic [7:0] bus_out1;

    int checks = 0, failures = 0;

    // model state: k = cycles since the transfer's accepting edge
    bit         m_active, m_pend, m1_active;
    int         m_k, m1_k;
    logic [7:0] m_a, m_d, m_qa, m_qd, m1_a, m1_d;
    logic       prev_aod, prev_cs, prev_aod1, prev_cs1;

    always #5 clk = ~clk;

    rtc_write dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .data(data),
        .busy(busy), .done(done), .pending(pending), .ChipSelect(cs), .Read(rd),
        .Write(wr), .AoD(aod), .bus_out(bus_out), .bus_oe(oe)
    );

    rtc_write #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .addr(addr), .data(data),
        .busy(busy1), .done(done1), .pending(pending1), .ChipSelect(cs1), .Read(rd1),
        .Write(wr1), .AoD(aod1), .bus_out(bus_out1), .bus_oe(oe1)
    );

    function automatic obs_t expect_at(input int k, input logic [7:0] a, input logic [7:0] d,
                                       input int s, input int p, input int h, input int g);
        obs_t e;
        int   j;
        e = '{busy: 1'b0, done: 1'b0, cs: 1'b1, rd: 1'b1, wr: 1'b1, aod: 1'b1, oe: 1'b0, bus: 8'h00};
        if (k <= 0) return e;
        e.busy = 1'b1;
        if (k <= s + p + h) begin
            e.cs = 1'b0; e.aod = 1'b0; e.oe = 1'b1; e.bus = a;
            e.wr = !(k > s && k <= s + p);
        end else if (k <= s + p + h + g) begin
            e.aod = 1'b0;
        end else if (k <= 2 * (s + p + h) + g) begin
            j = k - (s + p + h + g);
            e.cs = 1'b0; e.aod = 1'b1; e.oe = 1'b1; e.bus = d;
            e.wr = !(j > s && j <= s + p);
        end else begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    task automatic cmp_obs(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (busy,done,cs,rd,wr,aod,oe,bus) t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic st, input logic [7:0] a, input logic [7:0] d);
        bit was_done;
        was_done = m_active && (m_k == LEN + 1);
        if (!m_active) begin
            if (st) begin m_active = 1'b1; m_k = 1; m_a = a; m_d = d; end
        end else begin
            if (QUEUE && st && !m_pend && !was_done) begin
                m_pend = 1'b1; m_qa = a; m_qd = d;
            end
            if (was_done) begin
                if (m_pend) begin m_k = 1; m_a = m_qa; m_d = m_qd; m_pend = 1'b0; end
                else begin m_active = 1'b0; end
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic model1_edge(input logic st, input logic [7:0] a, input logic [7:0] d);
        if (!m1_active) begin
            if (st) begin m1_active = 1'b1; m1_k = 1; m1_a = a; m1_d = d; end
        end else if (m1_k == LEN1 + 1) begin
            m1_active = 1'b0;
        end else begin
            m1_k++;
        end
    endtask

    task automatic check_now();
        obs_t got, exp;
        got = {busy, done, cs, rd, wr, aod, oe, bus_out};
        exp = expect_at(m_active ? m_k : 0, m_a, m_d, TS, TP, TH, TG);
        cmp_obs("outputs", got, exp);
        cmp_int("pending", int'(pending), int'(m_pend));
        cmp_int("strobe_order", int'(!wr && cs), 0);
        cmp_int("aod_change_cs_low", int'((aod !== prev_aod) && !prev_cs), 0);
        prev_aod = aod; prev_cs = cs;
        got = {busy1, done1, cs1, rd1, wr1, aod1, oe1, bus_out1};
        exp = expect_at(m1_active ? m1_k : 0, m1_a, m1_d, 1, 1, 1, 1);
        cmp_obs("outputs_short", got, exp);
        cmp_int("strobe_order_short", int'(!wr1 && cs1), 0);
        cmp_int("aod_change_cs_low_short", int'((aod1 !== prev_aod1) && !prev_cs1), 0);
        prev_aod1 = aod1; prev_cs1 = cs1;
    endtask

    task automatic tick(input logic st, input logic [7:0] a, input logic [7:0] d, input logic st1);
        start = st; addr = a; data = d; start1 = st1;
        @(posedge clk);
        model_edge(st, a, d);
        model1_edge(st1, a, d);
        #1;
        start = 1'b0; start1 = 1'b0;
        check_now();
    endtask

    // Assert reset mid-cycle; outputs must go idle before the next edge.
    task automatic reset_mid();
        #3;
        reset = 1'b1;
        #1;
        m_active = 1'b0; m_pend = 1'b0; m1_active = 1'b0;
        prev_aod = 1'b1; prev_cs = 1'b1; prev_aod1 = 1'b1; prev_cs1 = 1'b1;
        check_now();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vec_t vec[3];
        int   n_done, first_done, second_done, wr_low, gap_cyc, t_done;
        logic st;
        logic [7:0] a, d;

        vec[0] = '{a: 8'h21, d: 8'h45, a2: 8'h00, d2: 8'h00, s2: 0, s3: 0, n: 1, d1: 23, d2t: 0};
        vec[1] = '{a: 8'hA5, d: 8'h3C, a2: 8'h77, d2: 8'h88, s2: 5, s3: 23,
                   n: QUEUE ? 2 : 1, d1: 23, d2t: QUEUE ? 46 : 0};
        vec[2] = '{a: 8'h5A, d: 8'h01, a2: 8'h22, d2: 8'h10, s2: 3, s3: 4,
                   n: QUEUE ? 2 : 1, d1: 23, d2t: QUEUE ? 46 : 0};

        reset = 1'b1; start = 1'b0; start1 = 1'b0; addr = 8'h00; data = 8'h00;
        m_active = 1'b0; m_pend = 1'b0; m1_active = 1'b0; m_k = 0; m1_k = 0;
        m_a = 8'h00; m_d = 8'h00; m_qa = 8'h00; m_qd = 8'h00; m1_a = 8'h00; m1_d = 8'h00;
        prev_aod = 1'b1; prev_cs = 1'b1; prev_aod1 = 1'b1; prev_cs1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_now();
        reset = 1'b0;

        // Directed vectors: extra starts at given cycles after acceptance.
        for (int i = 0; i < 3; i++) begin
            n_done = 0; first_done = 0; second_done = 0; wr_low = 0; gap_cyc = 0;
            for (int t = 1; t <= 60; t++) begin
                a = 8'($urandom); d = 8'($urandom);
                if (t == 1) begin
                    st = 1'b1; a = vec[i].a; d = vec[i].d;
                end else if (vec[i].s2 > 0 && t == vec[i].s2 + 1) begin
                    st = 1'b1; a = vec[i].a2; d = vec[i].d2;
                end else if (vec[i].s3 > 0 && t == vec[i].s3 + 1) begin
                    st = 1'b1;
                end else begin
                    st = 1'b0;
                end
                tick(st, a, d, 1'b0);
                if (done === 1'b1) begin
                    n_done++;
                    if (n_done == 1) first_done = t; else second_done = t;
                end
                if (wr === 1'b0) wr_low++;
                if (busy === 1'b1 && cs === 1'b1 && done === 1'b0) gap_cyc++;
            end
            cmp_int("vec_done_count", n_done, vec[i].n);
            cmp_int("vec_first_done", first_done, vec[i].d1);
            cmp_int("vec_second_done", second_done, vec[i].d2t);
            cmp_int("vec_write_low_cycles", wr_low, TP * 2 * vec[i].n);
            cmp_int("vec_gap_cycles", gap_cyc, TG * vec[i].n);
        end

        // Reset during D_PULSE, then a fresh transfer.
        tick(1'b1, 8'h3C, 8'hC3, 1'b0);
        for (int t = 2; t <= 17; t++) tick(1'b0, 8'h00, 8'h00, 1'b0);
        reset_mid();
        t_done = 0;
        for (int t = 1; t <= 26; t++) begin
            tick(t == 1, 8'h99, 8'h66, 1'b0);
            if (done === 1'b1 && t_done == 0) t_done = t;
        end
        cmp_int("after_reset_done", t_done, 23);

        // Minimum timings on the second instance.
        t_done = 0;
        for (int t = 1; t <= 12; t++) begin
            tick(1'b0, 8'h81, 8'h18, t == 1);
            if (done1 === 1'b1 && t_done == 0) t_done = t;
        end
        cmp_int("short_done", t_done, 8);

        // Random traffic with occasional mid-cycle resets.
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 149) == 0) begin
                reset_mid();
            end else begin
                tick($urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom), $urandom_range(0, 5) == 0 && !m1_active);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtc_write.md
RTC_WRITE -- requirements
Module: rtc_write

Interface
REQ-001 Parameter T_SETUP, default 2, cycles from ChipSelect fall to Write fall in each phase; legal range 1..15.
REQ-002 Parameter T_PULSE, default 5, cycles Write is held low in each phase; legal range 1..15.
REQ-003 Parameter T_HOLD, default 2, cycles from Write rise to ChipSelect rise in each phase; legal range 1..15.
REQ-004 Parameter T_GAP, default 4, cycles ChipSelect is high between the address phase and the data phase; legal range 1..15.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  single-cycle write request.
REQ-008 addr  input  8  RTC register address, latched on an accepted start.
REQ-009 data  input  8  value to write, latched on an accepted start.
REQ-010 busy  output  1  transaction in progress.
REQ-011 done  output  1  one-cycle pulse at transaction end.
REQ-012 pending  output  1  queued request held; constant 0 when RTC_WRITE_QUEUE_EN is absent.
REQ-013 ChipSelect, Read, Write, AoD  output  1 each  active-low RTC bus strobes; AoD=0 means address, AoD=1 means data.
REQ-014 bus_out  output  8  multiplexed address/data value.
REQ-015 bus_oe  output  1  tri-state enable for the multiplexed bus.

Function
REQ-016 All outputs shall be registered.
REQ-017 The idle state shall drive ChipSelect=1, Read=1, Write=1, AoD=1, bus_oe=0, bus_out=0, busy=0, done=0.
REQ-018 The FSM shall use the states IDLE, A_SETUP, A_PULSE, A_HOLD, GAP, D_SETUP, D_PULSE, D_HOLD, DONE, timed by one 4-bit down-counter reloaded on each state entry.
REQ-019 A start seen in IDLE shall latch addr and data and enter A_SETUP on that edge.
REQ-020 A_SETUP/A_PULSE/A_HOLD shall drive AoD=0, bus_oe=1, bus_out=addr, and ChipSelect=0.
REQ-021 Write shall be 0 only in A_PULSE.
REQ-022 GAP shall drive ChipSelect=1, Write=1, and bus_oe=0.
REQ-023 D_SETUP/D_PULSE/D_HOLD shall mirror the address phase with AoD=1 and bus_out=data, and Write=0 only in D_PULSE.
REQ-024 Each state shall last exactly its parameter's number of cycles.
REQ-025 DONE shall last 1 cycle with idle bus levels and done=1, then return to IDLE.
REQ-026 busy shall be 1 from the cycle after acceptance through the DONE cycle inclusive.
REQ-027 Latency from the accepting edge to done=1 shall be 2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP+1 cycles (23 with defaults).
REQ-028 Read shall remain 1 at all times.
REQ-029 Write=0 shall never coincide with ChipSelect=1.
REQ-030 AoD shall change only while ChipSelect=1.
REQ-031 start while busy=1 shall be ignored, with no effect on the current transfer.
REQ-032 start in the DONE cycle shall be ignored.

Reset
REQ-033 Asserting reset shall immediately force every output to the REQ-017 idle values, even mid-transfer.
REQ-034 Asserting reset shall clear the counter, the latched addr/data, and the queue, and place the FSM in IDLE.
REQ-035 The first start after reset deassertion shall be accepted normally.

Configuration
REQ-036 With macro RTC_WRITE_QUEUE_EN defined, a start while busy=1 and pending=0 shall latch addr/data into a one-entry holding register and set pending=1.
REQ-037 With RTC_WRITE_QUEUE_EN defined, DONE shall then go directly to A_SETUP using the held values, keeping busy=1 and clearing pending on that edge.
REQ-038 With RTC_WRITE_QUEUE_EN defined, a start while pending=1 shall be ignored.
REQ-039 Without RTC_WRITE_QUEUE_EN, no holding register shall exist, pending shall be tied to 0, and REQ-031 shall govern.

Structure
REQ-040 A shared package shall hold the FSM state encoding, the default timing constants, and the AoD address/data level constants.
REQ-041 One sub-module, rtc_phase_timer (loadable 4-bit down-counter with a zero flag), shall be instantiated once.

Verification
REQ-042 Defaults, start with addr=0x21, data=0x45 -> bus_out=0x21 with AoD=0 during the first CS-low window, Write low exactly 5 cycles, CS high 4 cycles, then bus_out=0x45 with AoD=1, done at cycle 23, Read=1 throughout.
REQ-043 start asserted again at cycles 5 and 23 of a transfer (no macro) -> both ignored, exactly one done pulse.
REQ-044 reset asserted during D_PULSE -> in the same cycle Write=1, ChipSelect=1, bus_oe=0, busy=0; a fresh start afterwards completes in 23 cycles.
REQ-045 T_SETUP=T_PULSE=T_HOLD=T_GAP=1 -> done at cycle 8, strobe ordering per REQ-029/REQ-030 holds.
REQ-046 RTC_WRITE_QUEUE_EN defined, second start (addr=0x22, data=0x10) at cycle 3 and third at cycle 4 -> pending=1, busy stays 1 across two transfers, done at cycles 23 and 46, third request dropped.
